// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: CPU byte FIFO plus optional RX-echo holding register, arbitrated
// round-robin into a start/busy handshake with the TX engine. Optional echo path: UART_ECHO_EN.
module uart_tx_sched #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          cpu_wr,
  input  logic [DATA_W-1:0]             cpu_data,
  output logic                          cpu_ready,
  input  logic                          echo_wr,
  input  logic [DATA_W-1:0]             echo_data,
  output logic                          echo_drop,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          irq_done,
  output logic                          tx_err,
  input  logic                          irq_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
  typedef enum logic {SRC_CPU, SRC_ECHO} src_t;

  state_t                           state;
  src_t                             rr;
  logic [CW-1:0]                    cnt;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                    wr_ptr, rd_ptr;
  logic [LW-1:0]                    lvl_nxt;
  logic                             wr_acc, cpu_pend, idle_go, grant_cpu, grant_echo;
  logic                             echo_full;
  logic [DATA_W-1:0]                echo_q;

  assign cpu_pend   = (fifo_level != '0);
  // Space is judged on the registered level only, so a pop in the same cycle never helps.
  assign wr_acc     = cpu_wr && (fifo_level < LW'(FIFO_DEPTH));
  assign idle_go    = (state == IDLE) && !tx_busy && (cpu_pend || echo_full);
  assign grant_cpu  = idle_go && cpu_pend && (!echo_full || rr == SRC_ECHO);
  assign grant_echo = idle_go && echo_full && (!cpu_pend || rr == SRC_CPU);

  always_comb begin
    lvl_nxt = fifo_level;
    if (wr_acc && !grant_cpu)      lvl_nxt = fifo_level + 1'b1;
    else if (!wr_acc && grant_cpu) lvl_nxt = fifo_level - 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cpu_ready  <= 1'b1;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= cpu_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (grant_cpu) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= lvl_nxt;
      cpu_ready  <= (lvl_nxt < LW'(FIFO_DEPTH));
    end
  end

`ifdef UART_ECHO_EN
  // Single-entry holding register; a byte being granted this cycle frees the slot.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      echo_full <= 1'b0;
      echo_q    <= '0;
      echo_drop <= 1'b0;
    end else begin
      echo_drop <= 1'b0;
      if (echo_wr) begin
        if (!echo_full || grant_echo) begin
          echo_full <= 1'b1;
          echo_q    <= echo_data;
        end else begin
          echo_drop <= 1'b1;
        end
      end else if (grant_echo) begin
        echo_full <= 1'b0;
      end
    end
  end
`else
  logic unused_echo;
  assign unused_echo = ^{echo_wr, echo_data};
  assign echo_full   = 1'b0;
  assign echo_q      = '0;
  assign echo_drop   = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr       <= SRC_ECHO;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      irq_done <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (irq_clr) begin
        irq_done <= 1'b0;
        tx_err   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            tx_data  <= mem[rd_ptr];
            rr       <= SRC_CPU;
            tx_start <= 1'b1;
            state    <= START;
          end else if (grant_echo) begin
            tx_data  <= echo_q;
            rr       <= SRC_ECHO;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            irq_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
